uart_tx_cfg: RTL and testbench

//  Parametrised UART transmitter for the iCE40 designs. Generates its own baud timing as a

---
 rtl/uart_tx_cfg_pkg.sv | 7 +
 rtl/uart_tx_fifo.sv | 42 ++++
 rtl/uart_tx_cfg.sv | 95 +++++++++
 tb/tb_uart_tx_cfg.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_cfg_pkg.sv
// uart_tx_cfg_pkg: parity-mode constants and transmitter FSM state encoding
package uart_tx_cfg_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD = 1;
  localparam int PARITY_EVEN = 2;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO (clk, rst, wdata/push in, pop in, rdata/full/empty/count out); push ignored when full
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     push,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of 2 and >= 2");
  end
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign rdata = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with FIFO (hwclk, rst, s_data/s_valid/s_ready in, tx/busy/txdone/fifo_count out)
module uart_tx_cfg
  import uart_tx_cfg_pkg::*;
#(
  parameter int CLK_HZ = 12_000_000,
  parameter int BAUD = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          hwclk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          txdone,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW = $clog2(DIV);
  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
    $error("uart_tx_cfg: illegal parameters");
  end
  state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] bitn;
  logic [DATA_BITS-1:0] shreg, fdata;
  logic par, fempty, full, pop, bit_end;
  assign bit_end = cnt == CW'(DIV - 1);
  assign pop = state == ST_IDLE && !fempty;
  assign s_ready = !full;
  assign busy = state != ST_IDLE || !fempty;
  uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(hwclk), .rst(rst), .wdata(s_data), .push(s_valid), .pop(pop),
    .rdata(fdata), .full(full), .empty(fempty), .count(fifo_count)
  );
  always_ff @(posedge hwclk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      bitn <= '0;
      shreg <= '0;
      par <= 1'b0;
      tx <= 1'b1;
      txdone <= 1'b0;
    end else begin
      // counter held at zero in IDLE so each frame starts on a fresh bit boundary
      cnt <= (state == ST_IDLE || bit_end) ? '0 : cnt + 1'b1;
      // registered, so raised one cycle early to land on the last stop-bit cycle
      txdone <= state == ST_STOP && bitn == 4'(STOP_BITS - 1) && cnt == CW'(DIV - 2);
      case (state)
        ST_IDLE:
          if (pop) begin
            shreg <= fdata;
            par <= PARITY == PARITY_EVEN ? ^fdata : ~^fdata;
            state <= ST_START;
            tx <= 1'b0;
          end
        ST_START:
          if (bit_end) begin
            state <= ST_DATA;
            bitn <= '0;
            tx <= shreg[0];
          end
        ST_DATA:
          if (bit_end) begin
            shreg <= shreg >> 1;
            bitn <= bitn + 1'b1;
            tx <= shreg[1];
            if (bitn == 4'(DATA_BITS - 1)) begin
              bitn <= '0;
              state <= PARITY != PARITY_NONE ? ST_PARITY : ST_STOP;
              tx <= PARITY != PARITY_NONE ? par : 1'b1;
            end
          end
        ST_PARITY:
          if (bit_end) begin
            state <= ST_STOP;
            bitn <= '0;
            tx <= 1'b1;
          end
        ST_STOP:
          if (bit_end) begin
            bitn <= bitn + 1'b1;
            if (bitn == 4'(STOP_BITS - 1)) state <= ST_IDLE;
          end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: table-driven and scoreboard checks of uart_tx_cfg in 8N1, 8E2, 8O1 and 7N1 at DIV=8
module tb_uart_tx_cfg;
  localparam int DIV = 8;
  typedef struct { logic [8:0] data; logic par; } sb_t;
  typedef struct { int k; logic [7:0] din; logic [8:0] dexp; logic par; } vec_t;
  logic hwclk = 0, rst = 1;
  logic [7:0] sd = 0;
  logic sv [4];
  logic sr [4], tx_w [4], bz [4], td [4];
  logic [2:0] fc [4];
  int ND [4] = '{8, 8, 8, 7};
  int NP [4] = '{0, 1, 1, 0};
  int NS [4] = '{1, 2, 1, 1};
  int cyc = 0, checks = 0, errors = 0;
  sb_t sb [$];
  always #5 hwclk = ~hwclk;
  always @(posedge hwclk) cyc <= cyc + 1;
  uart_tx_cfg #(.CLK_HZ(16), .BAUD(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .hwclk(hwclk), .rst(rst), .s_data(sd), .s_valid(sv[0]), .s_ready(sr[0]),
    .tx(tx_w[0]), .busy(bz[0]), .txdone(td[0]), .fifo_count(fc[0]));
  uart_tx_cfg #(.CLK_HZ(16), .BAUD(2), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .hwclk(hwclk), .rst(rst), .s_data(sd), .s_valid(sv[1]), .s_ready(sr[1]),
    .tx(tx_w[1]), .busy(bz[1]), .txdone(td[1]), .fifo_count(fc[1]));
  uart_tx_cfg #(.CLK_HZ(16), .BAUD(2), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .hwclk(hwclk), .rst(rst), .s_data(sd), .s_valid(sv[2]), .s_ready(sr[2]),
    .tx(tx_w[2]), .busy(bz[2]), .txdone(td[2]), .fifo_count(fc[2]));
  uart_tx_cfg #(.CLK_HZ(16), .BAUD(2), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
    .hwclk(hwclk), .rst(rst), .s_data(sd[6:0]), .s_valid(sv[3]), .s_ready(sr[3]),
    .tx(tx_w[3]), .busy(bz[3]), .txdone(td[3]), .fifo_count(fc[3]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic [8:0] de, input logic p, output int n);
    sb_t e;
    sd = d;
    sv[k] = 1;
    n = cyc;
    chk("push_ready", sr[k], 1);
    e.data = de;
    e.par = p;
    sb.push_back(e);
    @(negedge hwclk);
    sv[k] = 0;
  endtask

  task automatic recv(input int k, output int st);
    sb_t e;
    int w, L;
    bit ok, dn_ok;
    logic exp_b;
    w = 0;
    while (tx_w[k] !== 1'b0 && w < 400) begin
      @(negedge hwclk);
      w++;
    end
    chk("start_seen", tx_w[k], 0);
    st = -1;
    if (tx_w[k] !== 1'b0) return;
    st = cyc;
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    L = 1 + ND[k] + NP[k] + NS[k];
    dn_ok = 1;
    for (int b = 0; b < L; b++) begin
      exp_b = b == 0 ? 1'b0 : b <= ND[k] ? e.data[b-1] : (NP[k] != 0 && b == ND[k] + 1) ? e.par : 1'b1;
      ok = 1;
      for (int c = 0; c < DIV; c++) begin
        if (tx_w[k] !== exp_b) ok = 0;
        if (td[k] !== ((b == L - 1 && c == DIV - 1) ? 1'b1 : 1'b0)) dn_ok = 0;
        if (!(b == L - 1 && c == DIV - 1)) @(negedge hwclk);
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL frame_bit k=%0d bit=%0d: line not held at required %0b for %0d cycles", k, b, exp_b, DIV);
      end
    end
    chk("txdone_last_cycle_only", dn_ok, 1);
  endtask

  initial begin
    vec_t v [8];
    logic [7:0] fb [6];
    int acc [6];
    int sts [6];
    int n, st, n0;
    bit ok;
    foreach (sv[i]) sv[i] = 0;
    v[0] = '{0, 8'h35, 9'h035, 1'b0};
    v[1] = '{0, 8'hA5, 9'h0A5, 1'b0};
    v[2] = '{1, 8'h07, 9'h007, 1'b1};
    v[3] = '{1, 8'h80, 9'h080, 1'b1};
    v[4] = '{2, 8'h07, 9'h007, 1'b0};
    v[5] = '{2, 8'h00, 9'h000, 1'b1};
    v[6] = '{3, 8'hFF, 9'h07F, 1'b0};
    v[7] = '{3, 8'h2A, 9'h02A, 1'b0};
    fb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    repeat (3) @(negedge hwclk);
    rst = 0;
    @(negedge hwclk);
    for (int k = 0; k < 4; k++) begin
      chk("reset_tx", tx_w[k], 1);
      chk("reset_ready", sr[k], 1);
      chk("reset_busy", bz[k], 0);
      chk("reset_txdone", td[k], 0);
      chk("reset_count", fc[k], 0);
    end
    for (int i = 0; i < 8; i++) begin
      repeat (2) @(negedge hwclk);
      push(v[i].k, v[i].din, v[i].dexp, v[i].par, n);
      recv(v[i].k, st);
      chk("latency", st, n + 2);
      @(negedge hwclk);
      chk("busy_after_frame", bz[v[i].k], 0);
      chk("count_after_frame", fc[v[i].k], 0);
    end
    repeat (3) @(negedge hwclk);
    n0 = cyc;
    fork
      begin
        sb_t e;
        int idx, g;
        idx = 0;
        g = 0;
        sv[0] = 1;
        while (idx < 6 && g < 2000) begin
          sd = fb[idx];
          if (sr[0] === 1'b1) begin
            e.data = {1'b0, fb[idx]};
            e.par = 1'b0;
            sb.push_back(e);
            acc[idx] = cyc;
            idx++;
          end
          @(negedge hwclk);
          g++;
        end
        sv[0] = 0;
        chk("fifo_all_accepted", idx, 6);
      end
      begin
        repeat (5) @(negedge hwclk);
        chk("fifo_full_count", fc[0], 4);
        chk("fifo_full_ready", sr[0], 0);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          recv(0, sts[i]);
          if (i > 0) chk("back_to_back_gap", sts[i] - sts[i-1], 10 * DIV + 1);
        end
      end
    join
    chk("fifo_accept_byte4", acc[4], n0 + 4);
    chk("refused_on_full_pop", acc[5], n0 + 83);
    repeat (3) @(negedge hwclk);
    push(0, 8'h00, 9'h000, 1'b0, n);
    push(0, 8'h55, 9'h055, 1'b0, st);
    while (cyc < n + 36) @(negedge hwclk);
    chk("data_bit3_low", tx_w[0], 0);
    rst = 1;
    @(negedge hwclk);
    rst = 0;
    chk("abort_tx_high", tx_w[0], 1);
    chk("abort_count", fc[0], 0);
    chk("abort_busy", bz[0], 0);
    chk("abort_ready", sr[0], 1);
    sb.delete();
    ok = 1;
    repeat (100) begin
      @(negedge hwclk);
      if (tx_w[0] !== 1'b1 || td[0] !== 1'b0) ok = 0;
    end
    chk("abort_quiet_line", ok, 1);
    push(0, 8'h3C, 9'h03C, 1'b0, n);
    recv(0, st);
    chk("abort_new_latency", st, n + 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
